// File: rtl/axis_joiner_masked.sv
// Joins one packet from each enabled input stream, lowest index first, into a single output frame.
// The enable mask is captured once per frame; output beats pass through a 2-entry skid buffer.
module axis_joiner_masked #(
   parameter int AXIS_BYTES     = 1,
   parameter int AXIS_USER_BITS = 1,
   parameter int NUM_STREAMS    = 2,
   parameter int PASS_ALL_TLAST = 0,
   localparam int CTR_WIDTH     = (NUM_STREAMS == 1) ? 1 : $clog2(NUM_STREAMS)
) (
   input  logic                                   clk,
   input  logic                                   sreset,
   input  logic [NUM_STREAMS-1:0]                 enable_mask_i,
   output logic                                   frame_done_o,
   input  logic [NUM_STREAMS-1:0]                 axis_i_tvalid,
   output logic [NUM_STREAMS-1:0]                 axis_i_tready,
   input  logic [NUM_STREAMS-1:0]                 axis_i_tlast,
   input  logic [NUM_STREAMS*AXIS_BYTES-1:0]      axis_i_tkeep,
   input  logic [NUM_STREAMS*AXIS_BYTES*8-1:0]    axis_i_tdata,
   input  logic [NUM_STREAMS*AXIS_USER_BITS-1:0]  axis_i_tuser,
   output logic                                   axis_o_tvalid,
   input  logic                                   axis_o_tready,
   output logic                                   axis_o_tlast,
   output logic [AXIS_BYTES-1:0]                  axis_o_tkeep,
   output logic [AXIS_BYTES*8-1:0]                axis_o_tdata,
   output logic [AXIS_USER_BITS-1:0]              axis_o_tuser,
   output logic [CTR_WIDTH-1:0]                   axis_o_tid
);

   localparam int DW = AXIS_BYTES * 8;

   typedef enum logic {IDLE, ACTIVE} state_t;

   typedef struct packed {
      logic [CTR_WIDTH-1:0]      tid;
      logic                      fin;
      logic                      last;
      logic [AXIS_USER_BITS-1:0] user;
      logic [AXIS_BYTES-1:0]     keep;
      logic [DW-1:0]             data;
   } beat_t;

   state_t                 state_q;
   logic [NUM_STREAMS-1:0] mask_q;
   logic [CTR_WIDTH-1:0]   ctr_q;

   logic [CTR_WIDTH-1:0]   firstIdx;
   logic [CTR_WIDTH-1:0]   nextIdx;
   logic                   hasNext;
   logic                   inReady;
   logic                   push;
   logic                   pop;
   logic                   selLast;
   beat_t                  inBeat;

   logic                   oValid_q, oValid_d;
   logic                   sValid_q, sValid_d;
   beat_t                  oBeat_q, oBeat_d;
   beat_t                  sBeat_q, sBeat_d;

   // Lowest enabled stream for a new frame, and the next enabled stream above the current one.
   always_comb begin
      firstIdx = '0;
      nextIdx  = '0;
      hasNext  = 1'b0;
      for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
         if (enable_mask_i[i]) firstIdx = CTR_WIDTH'(i);
         if (mask_q[i] && (i > int'(ctr_q))) begin
            nextIdx = CTR_WIDTH'(i);
            hasNext = 1'b1;
         end
      end
   end

   always_comb begin
      inReady       = (state_q == ACTIVE) && !(oValid_q && sValid_q);
      axis_i_tready = inReady ? (NUM_STREAMS'(1) << ctr_q) : '0;
      push          = inReady && axis_i_tvalid[ctr_q];
      pop           = oValid_q && axis_o_tready;
      selLast       = axis_i_tlast[ctr_q];
      inBeat.tid    = ctr_q;
      inBeat.fin    = selLast && !hasNext;
      inBeat.last   = (PASS_ALL_TLAST != 0) ? selLast : (selLast && !hasNext);
      inBeat.user   = axis_i_tuser[int'(ctr_q)*AXIS_USER_BITS +: AXIS_USER_BITS];
      inBeat.keep   = axis_i_tkeep[int'(ctr_q)*AXIS_BYTES +: AXIS_BYTES];
      inBeat.data   = axis_i_tdata[int'(ctr_q)*DW +: DW];
   end

   always_ff @(posedge clk) begin
      if (sreset) begin
         state_q <= IDLE;
         mask_q  <= '0;
         ctr_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               mask_q <= enable_mask_i;
               if (|enable_mask_i) begin
                  ctr_q   <= firstIdx;
                  state_q <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (push && selLast) begin
                  if (hasNext) ctr_q <= nextIdx;
                  else         state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // The skid slot only fills when a beat arrives while the output slot is held by back-pressure.
   always_comb begin
      oValid_d = oValid_q;
      oBeat_d  = oBeat_q;
      sValid_d = sValid_q;
      sBeat_d  = sBeat_q;
      if (!oValid_q || pop) begin
         if (sValid_q) begin
            oValid_d = 1'b1;
            oBeat_d  = sBeat_q;
            sValid_d = push;
            if (push) sBeat_d = inBeat;
         end else begin
            oValid_d = push;
            if (push) oBeat_d = inBeat;
         end
      end else if (push) begin
         sValid_d = 1'b1;
         sBeat_d  = inBeat;
      end
   end

   always_ff @(posedge clk) begin
      if (sreset) begin
         oValid_q <= 1'b0;
         sValid_q <= 1'b0;
      end else begin
         oValid_q <= oValid_d;
         sValid_q <= sValid_d;
         oBeat_q  <= oBeat_d;
         sBeat_q  <= sBeat_d;
      end
   end

   assign axis_o_tvalid = oValid_q;
   assign axis_o_tlast  = oBeat_q.last;
   assign axis_o_tkeep  = oBeat_q.keep;
   assign axis_o_tdata  = oBeat_q.data;
   assign axis_o_tuser  = oBeat_q.user;
   assign axis_o_tid    = oBeat_q.tid;
   assign frame_done_o  = pop && oBeat_q.fin;

endmodule

// File: tb/tb_axis_joiner_masked.sv
// Directed bench for axis_joiner_masked: two instances share inputs, one in each tlast mode.
// A background process drives the sources and collects output beats; the main block runs the scenarios.
module tb_axis_joiner_masked;

   typedef struct packed {
      logic [7:0] data;
      logic       keep;
      logic       user;
      logic       last;
   } srcBeat_t;

   typedef struct packed {
      logic [7:0] data;
      logic       keep;
      logic       user;
      logic [1:0] tid;
      logic       last;
      logic       last2;
      logic       done;
      logic       done2;
   } outBeat_t;

   logic        clk = 1'b0;
   logic        sreset;
   logic [2:0]  enableMask;
   logic        frameDone, frameDone2;
   logic [2:0]  iValid, iReady, iReady2, iLast, iKeep, iUser;
   logic [23:0] iData;
   logic        oValid, oValid2, oReady, oLast, oLast2;
   logic        oKeep, oKeep2, oUser, oUser2;
   logic [7:0]  oData, oData2;
   logic [1:0]  oTid, oTid2;

   srcBeat_t srcQ [3][$];
   outBeat_t obsQ [$];
   outBeat_t expQ [$];

   int         nChecks = 0;
   int         nErrors = 0;
   int         occ = 0;
   int         readyMode = 0;
   logic [2:0] expMask = 3'b000;

   always #5 clk = ~clk;

   axis_joiner_masked #(.AXIS_BYTES(1), .AXIS_USER_BITS(1), .NUM_STREAMS(3), .PASS_ALL_TLAST(0)) dut (
      .clk(clk), .sreset(sreset), .enable_mask_i(enableMask), .frame_done_o(frameDone),
      .axis_i_tvalid(iValid), .axis_i_tready(iReady), .axis_i_tlast(iLast),
      .axis_i_tkeep(iKeep), .axis_i_tdata(iData), .axis_i_tuser(iUser),
      .axis_o_tvalid(oValid), .axis_o_tready(oReady), .axis_o_tlast(oLast),
      .axis_o_tkeep(oKeep), .axis_o_tdata(oData), .axis_o_tuser(oUser), .axis_o_tid(oTid));

   axis_joiner_masked #(.AXIS_BYTES(1), .AXIS_USER_BITS(1), .NUM_STREAMS(3), .PASS_ALL_TLAST(1)) dut2 (
      .clk(clk), .sreset(sreset), .enable_mask_i(enableMask), .frame_done_o(frameDone2),
      .axis_i_tvalid(iValid), .axis_i_tready(iReady2), .axis_i_tlast(iLast),
      .axis_i_tkeep(iKeep), .axis_i_tdata(iData), .axis_i_tuser(iUser),
      .axis_o_tvalid(oValid2), .axis_o_tready(oReady), .axis_o_tlast(oLast2),
      .axis_o_tkeep(oKeep2), .axis_o_tdata(oData2), .axis_o_tuser(oUser2), .axis_o_tid(oTid2));

   // One comparison: counts, asserts, and reports tag/observed/expected on mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nErrors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Queues one packet on stream s and, if wanted, its expected output beats.
   task automatic applyStimulus(input int s, input int len, input logic [7:0] base,
                                input bit expectIt, input bit highest);
      for (int b = 0; b < len; b++) begin
         srcBeat_t sb;
         outBeat_t eb;
         sb.data = base + 8'(b);
         sb.keep = ~b[0];
         sb.user = b[1] ^ s[0];
         sb.last = (b == len - 1);
         srcQ[s].push_back(sb);
         if (expectIt) begin
            eb.data  = sb.data;
            eb.keep  = sb.keep;
            eb.user  = sb.user;
            eb.tid   = 2'(s);
            eb.last  = sb.last && highest;
            eb.last2 = sb.last;
            eb.done  = sb.last && highest;
            eb.done2 = sb.last && highest;
            expQ.push_back(eb);
         end
      end
   endtask

   task automatic startFrame(input logic [2:0] m);
      enableMask = m;
      @(posedge clk); #2;
      enableMask = 3'b000;
   endtask

   task automatic waitBeats(input int n);
      for (int c = 0; c < 3000 && obsQ.size() < n; c++) @(posedge clk);
      repeat (6) @(posedge clk);
      #2;
   endtask

   task automatic checkFrame(input string tag);
      int n;
      checkOutput({tag, "_count"}, obsQ.size(), expQ.size());
      n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
      for (int i = 0; i < n; i++) begin
         checkOutput($sformatf("%s_b%0d_payload", tag, i),
                     {obsQ[i].data, obsQ[i].keep, obsQ[i].user}, {expQ[i].data, expQ[i].keep, expQ[i].user});
         checkOutput($sformatf("%s_b%0d_tid", tag, i), obsQ[i].tid, expQ[i].tid);
         checkOutput($sformatf("%s_b%0d_tlast", tag, i), {obsQ[i].last, obsQ[i].last2}, {expQ[i].last, expQ[i].last2});
         checkOutput($sformatf("%s_b%0d_done", tag, i), {obsQ[i].done, obsQ[i].done2}, {expQ[i].done, expQ[i].done2});
      end
      obsQ.delete();
      expQ.delete();
   endtask

   // Source driver, output ready generator and per-cycle protocol monitor, all on the falling edge.
   initial begin : driver
      logic [2:0]  hs;
      logic        outHs;
      logic        stallPrev;
      logic [14:0] prevOut, curOut;
      outBeat_t    ob;
      hs = '0;
      stallPrev = 1'b0;
      prevOut = '0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++)
            if (hs[i] && srcQ[i].size() > 0) void'(srcQ[i].pop_front());
         for (int i = 0; i < 3; i++) begin
            if (srcQ[i].size() > 0) begin
               iValid[i]       = 1'b1;
               iData[i*8 +: 8] = srcQ[i][0].data;
               iKeep[i]        = srcQ[i][0].keep;
               iUser[i]        = srcQ[i][0].user;
               iLast[i]        = srcQ[i][0].last;
            end else begin
               iValid[i]       = 1'b0;
               iData[i*8 +: 8] = 8'h00;
               iKeep[i]        = 1'b0;
               iUser[i]        = 1'b0;
               iLast[i]        = 1'b0;
            end
         end
         case (readyMode)
            0:       oReady = 1'b1;
            1:       oReady = 1'($urandom_range(0, 1));
            default: oReady = 1'b0;
         endcase
         #1;
         hs    = iValid & iReady;
         outHs = oValid && oReady;
         curOut = {oValid, oLast, oLast2, oKeep, oUser, oData, oTid};
         checkOutput("o_valid_vs_occupancy", oValid, (occ != 0));
         checkOutput("i_ready_outside_mask", iReady & ~expMask, 3'b000);
         checkOutput("i_ready_onehot", ($countones(iReady) <= 1), 1'b1);
         if (|iReady) checkOutput("i_ready_while_full", (occ < 2), 1'b1);
         if (stallPrev) checkOutput("o_stable_stalled", curOut, prevOut);
         if (!outHs) checkOutput("done_without_handshake", {frameDone, frameDone2}, 2'b00);
         if (outHs) begin
            ob.data  = oData;
            ob.keep  = oKeep;
            ob.user  = oUser;
            ob.tid   = oTid;
            ob.last  = oLast;
            ob.last2 = oLast2;
            ob.done  = frameDone;
            ob.done2 = frameDone2;
            obsQ.push_back(ob);
         end
         if (sreset) occ = 0;
         else        occ = occ + int'(|hs) - int'(outHs);
         stallPrev = oValid && !oReady && !sreset;
         prevOut   = curOut;
      end
   end

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin : main
      sreset     = 1'b1;
      enableMask = 3'b000;
      repeat (3) @(posedge clk);
      #2;
      sreset = 1'b0;
      checkOutput("reset_o_valid", oValid, 1'b0);
      checkOutput("reset_i_ready", iReady, 3'b000);
      checkOutput("reset_frame_done", frameDone, 1'b0);

      $display("[TB] all three streams, 2-beat packets");
      expMask = 3'b111;
      applyStimulus(0, 2, 8'h10, 1, 0);
      applyStimulus(1, 2, 8'h20, 1, 0);
      applyStimulus(2, 2, 8'h30, 1, 1);
      startFrame(3'b111);
      waitBeats(6);
      checkFrame("t1");

      $display("[TB] mask 101, stream 1 skipped");
      expMask = 3'b101;
      applyStimulus(0, 3, 8'h40, 1, 0);
      applyStimulus(1, 2, 8'h50, 0, 0);
      applyStimulus(2, 1, 8'h58, 1, 1);
      startFrame(3'b101);
      waitBeats(4);
      checkFrame("t2");
      checkOutput("t2_stream1_untouched", srcQ[1].size(), 2);
      srcQ[1].delete();

      $display("[TB] mask 0 holds idle, then mask 010");
      expMask = 3'b000;
      applyStimulus(1, 3, 8'h60, 1, 1);
      repeat (10) @(posedge clk);
      #2;
      checkOutput("t3_idle_no_output", obsQ.size(), 0);
      checkOutput("t3_idle_ready", iReady, 3'b000);
      expMask = 3'b010;
      startFrame(3'b010);
      waitBeats(3);
      checkFrame("t3");

      $display("[TB] random output back-pressure, 4-beat packets");
      readyMode = 1;
      expMask   = 3'b111;
      applyStimulus(0, 4, 8'h70, 1, 0);
      applyStimulus(1, 4, 8'h80, 1, 0);
      applyStimulus(2, 4, 8'h90, 1, 1);
      startFrame(3'b111);
      waitBeats(12);
      checkFrame("t4");
      readyMode = 0;

      $display("[TB] mask 011, tlast forwarding compared across both modes");
      expMask = 3'b011;
      applyStimulus(0, 2, 8'hA0, 1, 0);
      applyStimulus(1, 3, 8'hB0, 1, 1);
      startFrame(3'b011);
      waitBeats(5);
      checkFrame("t5");

      $display("[TB] reset with two beats buffered");
      readyMode = 2;
      expMask   = 3'b111;
      applyStimulus(0, 4, 8'hC0, 0, 0);
      startFrame(3'b111);
      for (int c = 0; c < 200 && occ != 2; c++) @(posedge clk);
      #2;
      checkOutput("t6_full_ready", iReady, 3'b000);
      checkOutput("t6_full_valid", oValid, 1'b1);
      sreset = 1'b1;
      @(posedge clk); #2;
      checkOutput("t6_after_reset_valid", oValid, 1'b0);
      checkOutput("t6_after_reset_ready", iReady, 3'b000);
      sreset = 1'b0;
      for (int i = 0; i < 3; i++) srcQ[i].delete();
      obsQ.delete();
      expQ.delete();
      readyMode = 0;
      applyStimulus(1, 2, 8'hD0, 1, 0);
      applyStimulus(2, 2, 8'hE0, 1, 1);
      startFrame(3'b110);
      waitBeats(4);
      checkFrame("t6");

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
